// File: rtl/riscv_defs.sv
// Shared RISC-V constants for the fetch stage and the control unit:
// major opcodes, canonical NOP/ECALL words and fetch FSM state encodings.
package riscv_defs;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Word index of a byte address inside an instruction memory of 2**aw words.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr, input int aw);
        logic [31:0] mask;
        mask = (32'd1 << aw) - 32'd1;
        return (byte_addr >> 2) & mask;
    endfunction

endpackage

// File: rtl/busca_instrucao_if.sv
// Fetch-stage signal bundle: program-load port, next-PC controls from
// the core, and the instruction/PC/status outputs of the fetch stage.
interface busca_instrucao_if #(
    parameter int XLEN = 32,
    parameter int AW   = 8
);
    logic            start;
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [31:0]     prog_data;
    logic            branch;
    logic            zero;
    logic [XLEN-1:0] imm;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic            valid;
    logic            halted;
    logic [31:0]     instret;

    modport slave (
        input  start, prog_we, prog_addr, prog_data, branch, zero, imm,
        output pc, pc_plus4, instr, opcode, valid, halted, instret
    );

    modport master (
        output start, prog_we, prog_addr, prog_data, branch, zero, imm,
        input  pc, pc_plus4, instr, opcode, valid, halted, instret
    );
endinterface

// File: rtl/memoria_instrucao.sv
// Instruction memory: one synchronous write port for program load and one
// combinational read port for zero-latency fetch. Contents survive reset.
module memoria_instrucao #(
    parameter int IMEM_WORDS = 256,
    parameter int AW         = $clog2(IMEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [IMEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: PC register, next-PC mux, run/halt FSM,
// retired-instruction counter and the instruction memory instance.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_LOAD | program load; pc held at RESET_PC, nothing valid
//   ST_RUN  | fetching; valid unless ECALL or fault, which go to ST_HALT
//   ST_HALT | stopped; pc and instret frozen until reset
module busca_instrucao
    import riscv_defs::*;
#(
    parameter int              XLEN       = 32,
    parameter int              IMEM_WORDS = 256,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input logic               clk,
    input logic               reset,
    busca_instrucao_if.slave  bus
);

    localparam int AW = $clog2(IMEM_WORDS);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instret_q, instret_d;

    logic [31:0]     raw_word;
    logic            misaligned;
    logic            out_of_range;
    logic            stop;
    logic            valid;
    logic            mem_we;

    memoria_instrucao #(
        .IMEM_WORDS (IMEM_WORDS),
        .AW         (AW)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc_q[AW+1:2]),
        .rdata (raw_word)
    );

    // Any PC bit above the memory window means the address is past the end.
    assign misaligned   = |pc_q[1:0];
    assign out_of_range = |pc_q[XLEN-1:AW+2];
    assign stop         = (raw_word == ECALL_INSTR) || misaligned || out_of_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            pc_q      <= RESET_PC;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        valid     = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            ST_LOAD: begin
                mem_we = bus.prog_we;
                pc_d   = RESET_PC;
                if (bus.start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_HALT;
                end else begin
                    valid     = 1'b1;
                    // Misaligned branch targets are taken; the fault shows up next cycle.
                    pc_d      = (bus.branch && bus.zero) ? pc_q + bus.imm : pc_q + XLEN'(4);
                    instret_d = instret_q + 32'd1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_q + XLEN'(4);
    assign bus.instr    = valid ? raw_word : NOP_INSTR;
    assign bus.opcode   = bus.instr[6:0];
    assign bus.valid    = valid;
    assign bus.halted   = (state_q == ST_HALT);
    assign bus.instret  = instret_q;

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction-fetch stage of the single-cycle RISC-V core. Holds the PC, the instruction memory and its program-load port, and computes the next PC from the `Branch` signal (control unit) and the ALU `zero` flag. Drives the current instruction and its `opcode` field directly into `controle`. A small run/halt state machine gates when instructions are presented as valid.

## Interface
- `XLEN`, 32: data/address width.
- `IMEM_WORDS`, 256: instruction memory depth in 32-bit words (power of two).
- `RESET_PC`, 0: PC value after reset (word-aligned).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  leave LOAD and begin fetching.
- `prog_we`  in  1  program-load write enable (honoured in LOAD only).
- `prog_addr`  in  log2(IMEM_WORDS)  word address for program load.
- `prog_data`  in  32  instruction word to store.
- `branch`  in  1  `Branch` from the control unit.
- `zero`  in  1  ALU zero flag.
- `imm`  in  XLEN  sign-extended B-type byte offset (bit 0 = 0).
- `pc`  out  XLEN  current PC.
- `pc_plus4`  out  XLEN  `pc + 4`.
- `instr`  out  32  current instruction; NOP (0x00000013) when `valid` = 0.
- `opcode`  out  7  `instr[6:0]`, to `controle`.
- `valid`  out  1  `instr` is to be executed/committed this cycle.
- `halted`  out  1  core stopped.
- `instret`  out  32  count of cycles with `valid` = 1.

## Operation
- States: LOAD, RUN, HALT.
- LOAD (entered on reset):
  - `prog_we` = 1 writes `prog_data` to `imem[prog_addr]` at the edge.
  - `pc` is held at `RESET_PC`; `valid` = 0.
  - `start` = 1 moves to RUN. If `prog_we` and `start` are both asserted, the write still happens.
- RUN:
  - Raw word = `imem[pc[log2(IMEM_WORDS)+1:2]]`, read combinationally.
  - Fault condition: `pc[1:0]` ≠ 0, or `pc` ≥ 4·`IMEM_WORDS`.
  - If the raw word = ECALL (0x00000073) or the fault condition holds: `valid` = 0, `instr` = NOP, PC unchanged, next state HALT.
  - Otherwise `valid` = 1, `instr` = raw word, and at the edge:
    - `pc` ← (`branch` & `zero`) ? `pc + imm` : `pc + 4`.
    - `instret` ← `instret` + 1.
  - `prog_we` and `start` are ignored.
- HALT:
  - `halted` = 1, `valid` = 0, `pc` and `instret` frozen.
  - Exits only via `reset`.
- Arithmetic: PC adds are modulo 2^XLEN (wrap silently; the wrapped PC then faults via the range check). A branch to a misaligned target is taken; the fault is detected in the following cycle.
- `branch`, `zero` and `imm` are don't-care whenever `valid` = 0.
- Reset values: state = LOAD, `pc` = `RESET_PC`, `valid` = 0, `halted` = 0, `instret` = 0, `instr` = NOP, `opcode` = 0010011.
- Instruction memory contents are not cleared by reset. Reset in RUN or HALT returns to LOAD with the program intact.

## Timing
- Fetch is zero-latency: `instr`/`opcode` are combinational from `pc` and state. `controle` outputs settle in the same cycle.
- PC update, `instret` increment and state changes take one edge.
- First valid instruction appears in the cycle after `start` is sampled.
- A program word written at edge N is readable from cycle N+1.
- Write and read of the same address in one LOAD cycle cannot occur, because `valid` = 0 in LOAD.
- ECALL/fault cycle: `valid` drops in that same cycle; `halted` rises one edge later.

## Structure
- Shared package/header `riscv_defs`: opcode constants (R, LOAD, STORE, BRANCH, OP-IMM, SYSTEM), `NOP_INSTR`, `ECALL_INSTR`, fetch state encodings. The same constants are reused by `controle`.
- Sub-module `memoria_instrucao`: one synchronous write port, one combinational read port, parameterized by `IMEM_WORDS`.
- PC register, next-PC mux, FSM and `instret` live in `busca_instrucao`.

## Test plan
- **Reset/load:** assert `reset` 2 cycles → `pc` = 0, `valid` = 0, `halted` = 0, `instret` = 0, `opcode` = 0010011. Write 4 words at addresses 0–3 → read back via RUN.
- **Sequential fetch:** program add (0x002081B3), lw (0x0000A183), sw (0x0030A023), ECALL.
  - `start` → `opcode` sequence 0110011, 0000011, 0100011 with `pc` 0, 4, 8.
  - `valid` = 0 at `pc` = 12; `halted` = 1 next cycle; `instret` = 3.
- **Branch taken/not taken:**
  - At `pc` = 8 with `branch` = 1, `zero` = 1, `imm` = −8 → next `pc` = 0.
  - Same cycle with `zero` = 0 → next `pc` = 12.
- **Fault:** `imm` = 0x400 with `IMEM_WORDS` = 256 from `pc` = 0 → `pc` = 1024; `valid` = 0, `instr` = 0x00000013 that cycle, then HALT. `imm` = 2 → `pc` = 2, then HALT.
- **Ignored inputs / reset mid-run:**
  - `prog_we` during RUN does not change memory.
  - `reset` at `pc` = 8 → LOAD, `pc` = 0, `instret` = 0.
  - `start` again → same program re-executes from word 0.
- **Simultaneous:** `prog_we` + `start` in the same LOAD cycle writing address 0 with ECALL → first RUN cycle has `valid` = 0, then HALT.
